// File: rtl/wb_line_pkg.sv
// Shared types and constants for the 32-bit to 128-bit Wishbone line adapter.
package wb_line_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned LINE_BYTES = 16;
    localparam int unsigned LANE_W     = 32;
    localparam int unsigned LANE_BYTES = LANE_W / 8;
    localparam int unsigned LINE_W     = LINE_BYTES * 8;
    localparam int unsigned LANES      = LINE_BYTES / LANE_BYTES;

    // Lane index and line tag positions within a byte address
    localparam int unsigned LANE_LSB   = 2;
    localparam int unsigned LANE_MSB   = 3;
    localparam int unsigned LANE_IDX_W = LANE_MSB - LANE_LSB + 1;
    localparam int unsigned TAG_LSB    = 4;
    localparam int unsigned TAG_W      = ADDR_WIDTH - TAG_LSB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // Master-side request as held on the bus toward the DDR3 bridge
    typedef struct packed {
        logic                  cyc;
        logic                  we;
        logic [ADDR_WIDTH-1:0] adr;
        logic [LINE_BYTES-1:0] sel;
        logic [LINE_W-1:0]     dat;
    } line_req_t;

endpackage

// File: rtl/wb_line_lane.sv
// Lane helper: extracts a 32-bit lane from a line and builds the shifted
// byte select plus replicated write data for a lane write.
module wb_line_lane
    import wb_line_pkg::*;
(
    input  logic [LINE_W-1:0]     line,
    input  logic [LANE_IDX_W-1:0] lane,
    input  logic [LANE_BYTES-1:0] sel,
    input  logic [LANE_W-1:0]     dat,
    output logic [LANE_W-1:0]     lane_dat_c,
    output logic [LINE_BYTES-1:0] line_sel_c,
    output logic [LINE_W-1:0]     line_dat_c
);

    always_comb begin
        lane_dat_c = '0;
        line_sel_c = '0;
        line_dat_c = {LANES{dat}};
        for (int i = 0; i < int'(LANES); i++) begin
            if (lane == LANE_IDX_W'(i)) begin
                lane_dat_c = line[i*LANE_W +: LANE_W];
                line_sel_c = LINE_BYTES'(sel) << (i * LANE_BYTES);
            end
        end
    end

endmodule

// File: rtl/wb_line_adapter.sv
// 32-bit classic Wishbone slave to 128-bit line Wishbone master adapter.
// Define LINE_ADAPTER_RDBUF_EN to build the one-line read buffer.
module wb_line_adapter
    import wb_line_pkg::*;
(
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [LANE_BYTES-1:0] wb_sel_i,
    input  logic [LANE_W-1:0]     wb_dat_i,
    output logic [LANE_W-1:0]     wb_dat_o,
    output logic                  wb_ack_o,
    input  logic                  inv_i,
    output logic                  m_cyc_o,
    output logic                  m_stb_o,
    output logic                  m_we_o,
    output logic [ADDR_WIDTH-1:0] m_adr_o,
    output logic [LINE_BYTES-1:0] m_sel_o,
    output logic [LINE_W-1:0]     m_dat_o,
    input  logic [LINE_W-1:0]     m_dat_i,
    input  logic                  m_ack_i
);

    state_e                state_q, state_d;
    line_req_t             req_q, req_d;
    logic [LANE_IDX_W-1:0] lane_q, lane_d;
    logic                  ack_q, ack_d;
    logic                  abort_q, abort_d;
    logic [LANE_W-1:0]     dat_q, dat_d;

    logic [TAG_W-1:0]      req_tag;
    logic [LANE_IDX_W-1:0] req_lane;
    logic                  hit;
    logic [LINE_W-1:0]     lane_line;
    logic [LANE_IDX_W-1:0] lane_idx;
    logic [LANE_W-1:0]     lane_dat_c;
    logic [LINE_BYTES-1:0] line_sel_c;
    logic [LINE_W-1:0]     line_dat_c;
    logic                  unused_adr;

    assign req_tag    = wb_adr_i[ADDR_WIDTH-1:TAG_LSB];
    assign req_lane   = wb_adr_i[LANE_MSB:LANE_LSB];
    assign unused_adr = ^wb_adr_i[LANE_LSB-1:0];

    // In RD the lane comes from the returning line; otherwise from the request
    assign lane_idx = (state_q == ST_RD) ? lane_q : req_lane;

    wb_line_lane u_lane (
        .line       (lane_line),
        .lane       (lane_idx),
        .sel        (wb_sel_i),
        .dat        (wb_dat_i),
        .lane_dat_c (lane_dat_c),
        .line_sel_c (line_sel_c),
        .line_dat_c (line_dat_c)
    );

`ifdef LINE_ADAPTER_RDBUF_EN
    logic [LINE_W-1:0] buf_line_q;
    logic [TAG_W-1:0]  buf_tag_q;
    logic              buf_vld_q;
    logic              inv_pend_q;
    logic [LINE_W-1:0] merged;

    assign hit       = buf_vld_q && (buf_tag_q == req_tag);
    assign lane_line = (state_q == ST_RD) ? m_dat_i : buf_line_q;

    // Write-through merge of the in-flight lane write into the buffered line
    always_comb begin
        merged = buf_line_q;
        for (int i = 0; i < int'(LINE_BYTES); i++) begin
            if (req_q.sel[i]) begin
                merged[i*8 +: 8] = req_q.dat[i*8 +: 8];
            end
        end
    end

    // An invalidate seen at any point during a refill keeps that refill invalid
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            buf_line_q <= '0;
            buf_tag_q  <= '0;
            buf_vld_q  <= 1'b0;
            inv_pend_q <= 1'b0;
        end else if (state_q == ST_RD && m_ack_i) begin
            buf_line_q <= m_dat_i;
            buf_tag_q  <= req_q.adr[ADDR_WIDTH-1:TAG_LSB];
            buf_vld_q  <= !(inv_i || inv_pend_q);
            inv_pend_q <= 1'b0;
        end else begin
            if (state_q == ST_WR && m_ack_i && buf_vld_q &&
                buf_tag_q == req_q.adr[ADDR_WIDTH-1:TAG_LSB]) begin
                buf_line_q <= merged;
            end
            if (inv_i) begin
                buf_vld_q <= 1'b0;
            end
            inv_pend_q <= (state_q == ST_RD) && (inv_i || inv_pend_q);
        end
    end
`else
    logic unused_inv;

    assign hit        = 1'b0;
    assign lane_line  = m_dat_i;
    assign unused_inv = inv_i;
`endif

    // Next-state and registered-output values
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        lane_d  = lane_q;
        ack_d   = 1'b0;
        abort_d = abort_q;
        dat_d   = dat_q;

        unique case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                if (wb_cyc_i && wb_stb_i) begin
                    lane_d = req_lane;
                    if (wb_we_i) begin
                        req_d.cyc = 1'b1;
                        req_d.we  = 1'b1;
                        req_d.adr = {req_tag, {TAG_LSB{1'b0}}};
                        req_d.sel = line_sel_c;
                        req_d.dat = line_dat_c;
                        state_d   = ST_WR;
                    end else if (hit) begin
                        ack_d   = 1'b1;
                        dat_d   = lane_dat_c;
                        state_d = ST_RESP;
                    end else begin
                        req_d.cyc = 1'b1;
                        req_d.we  = 1'b0;
                        req_d.adr = {req_tag, {TAG_LSB{1'b0}}};
                        req_d.sel = '1;
                        req_d.dat = '0;
                        state_d   = ST_RD;
                    end
                end
            end
            ST_WR, ST_RD: begin
                if (!wb_cyc_i) begin
                    abort_d = 1'b1;
                end
                if (m_ack_i) begin
                    req_d = '0;
                    if (abort_q || !wb_cyc_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        ack_d   = 1'b1;
                        state_d = ST_RESP;
                        if (state_q == ST_RD) begin
                            dat_d = lane_dat_c;
                        end
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            lane_q  <= '0;
            ack_q   <= 1'b0;
            abort_q <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            lane_q  <= lane_d;
            ack_q   <= ack_d;
            abort_q <= abort_d;
            dat_q   <= dat_d;
        end
    end

    assign m_cyc_o  = req_q.cyc;
    assign m_stb_o  = req_q.cyc;
    assign m_we_o   = req_q.we;
    assign m_adr_o  = req_q.adr;
    assign m_sel_o  = req_q.sel;
    assign m_dat_o  = req_q.dat;
    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_wb_line_adapter.sv
// Directed self-checking bench for wb_line_adapter (with or without the read buffer).
module tb_wb_line_adapter;

`ifdef LINE_ADAPTER_RDBUF_EN
    localparam bit RDBUF = 1'b1;
`else
    localparam bit RDBUF = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         cyc, stb, we;
    logic [31:0]  adr;
    logic [3:0]   sel;
    logic [31:0]  dat_w;
    logic [31:0]  dat_r;
    logic         ack;
    logic         inv;
    logic         m_cyc, m_stb, m_we;
    logic [31:0]  m_adr;
    logic [15:0]  m_sel;
    logic [127:0] m_dat_o;
    logic [127:0] m_dat_i;
    logic         m_ack;

    int n_checks = 0;
    int n_pass   = 0;

    wb_line_adapter dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_we_i  (we),
        .wb_adr_i (adr),
        .wb_sel_i (sel),
        .wb_dat_i (dat_w),
        .wb_dat_o (dat_r),
        .wb_ack_o (ack),
        .inv_i    (inv),
        .m_cyc_o  (m_cyc),
        .m_stb_o  (m_stb),
        .m_we_o   (m_we),
        .m_adr_o  (m_adr),
        .m_sel_o  (m_sel),
        .m_dat_o  (m_dat_o),
        .m_dat_i  (m_dat_i),
        .m_ack_i  (m_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CPU access; dly is the downstream ack delay in cycles, inv_at the
    // cycle carrying an inv_i pulse (0 = request edge, -1 = none)
    task automatic do_access(input string tag, input bit we_a, input logic [31:0] adr_a,
                             input logic [3:0] sel_a, input logic [31:0] dat_a, input int dly,
                             input logic [127:0] rline, input int inv_at, input bit exp_ds,
                             input logic [15:0] exp_sel, input logic [31:0] exp_rd);
        cyc = 1'b1; stb = 1'b1; we = we_a; adr = adr_a; sel = sel_a; dat_w = dat_a;
        inv = (inv_at == 0);
        tick();
        inv = 1'b0;
        if (exp_ds) begin
            check({tag, ".cyc"}, 128'(m_cyc), 128'(1));
            check({tag, ".we"},  128'(m_we),  128'(we_a));
            check({tag, ".adr"}, 128'(m_adr), 128'(adr_a & 32'hFFFF_FFF0));
            check({tag, ".sel"}, 128'(m_sel), 128'(exp_sel));
            if (we_a) check({tag, ".mdat"}, m_dat_o, {4{dat_a}});
            for (int i = 1; i <= dly; i++) begin
                check({tag, ".early"}, 128'(ack),   128'(0));
                check({tag, ".hold"},  128'(m_stb), 128'(1));
                m_ack = (i == dly);
                inv   = (inv_at == i);
                if (i == dly) m_dat_i = rline;
                tick();
                m_ack = 1'b0;
                inv   = 1'b0;
            end
            check({tag, ".ack"},  128'(ack),   128'(1));
            check({tag, ".drop"}, 128'(m_stb), 128'(0));
            if (!we_a) check({tag, ".rdat"}, 128'(dat_r), 128'(exp_rd));
        end else begin
            check({tag, ".hitack"}, 128'(ack),   128'(1));
            check({tag, ".nostb"},  128'(m_stb), 128'(0));
            check({tag, ".hitdat"}, 128'(dat_r), 128'(exp_rd));
        end
        tick();
        check({tag, ".once"}, 128'(ack), 128'(0));
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    localparam logic [127:0] L20 = 128'h33333333_22222222_11111111_00000000;
    localparam logic [127:0] L2M = 128'h33333333_22222222_11111111_000000AB;
    localparam logic [127:0] LC  = 128'hCCCC0003_CCCC0002_CCCC0001_CCCC0000;
    localparam logic [127:0] LD  = 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000;
    localparam logic [127:0] LE  = 128'hEEEE0003_EEEE0002_EEEE0001_EEEE0000;
    localparam logic [127:0] LA  = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat_w = '0;
        inv = 1'b0; m_dat_i = '0; m_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst.cyc", 128'(m_cyc), 128'(0));
        check("rst.stb", 128'(m_stb), 128'(0));
        check("rst.ack", 128'(ack),   128'(0));
        check("rst.dat", 128'(dat_r), 128'(0));
        check("rst.adr", 128'(m_adr), 128'(0));

        // Lane-2 write, full select
        do_access("wr1", 1'b1, 32'h1000_0008, 4'b1111, 32'hDEADBEEF, 3, '0, -1, 1'b1, 16'h0F00, 32'h0);
        // Miss refill, then a second lane of the same line
        do_access("rd1", 1'b0, 32'h2000_0004, 4'b1111, 32'h0, 2, L20, -1, 1'b1, 16'hFFFF, 32'h11111111);
        do_access("rd2", 1'b0, 32'h2000_000C, 4'b1111, 32'h0, 1, L20, -1, !RDBUF, 16'hFFFF, 32'h33333333);
        // Byte write to a buffered line, then read back the merged lane
        do_access("wr2", 1'b1, 32'h2000_0000, 4'b0001, 32'h000000AB, 1, '0, -1, 1'b1, 16'h0001, 32'h0);
        do_access("rd3", 1'b0, 32'h2000_0000, 4'b1111, 32'h0, 1, L2M, -1, !RDBUF, 16'hFFFF, 32'h000000AB);
        // Zero-select write still goes downstream
        do_access("wr0", 1'b1, 32'h6000_0004, 4'b0000, 32'h55AA55AA, 2, '0, -1, 1'b1, 16'h0000, 32'h0);
        // Invalidate during a refill: data returned, line not retained
        do_access("inv1", 1'b0, 32'h3000_0008, 4'b1111, 32'h0, 3, LC, 1, 1'b1, 16'hFFFF, 32'hCCCC0002);
        do_access("inv2", 1'b0, 32'h3000_0008, 4'b1111, 32'h0, 1, LD, -1, 1'b1, 16'hFFFF, 32'hDDDD0002);
        // Invalidate coincident with a lookup: lookup sees the old state
        do_access("inv3", 1'b0, 32'h3000_0004, 4'b1111, 32'h0, 1, LD, 0, !RDBUF, 16'hFFFF, 32'hDDDD0001);
        do_access("inv4", 1'b0, 32'h3000_0004, 4'b1111, 32'h0, 1, LE, -1, 1'b1, 16'hFFFF, 32'hEEEE0001);

        // CPU abandons a read; the refill completes silently
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h4000_0000; sel = 4'hF;
        tick();
        check("abort.stb", 128'(m_stb), 128'(1));
        cyc = 1'b0; stb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort.noack", 128'(ack), 128'(0));
        end
        m_ack = 1'b1; m_dat_i = LA;
        tick();
        m_ack = 1'b0;
        check("abort.final", 128'(ack),   128'(0));
        check("abort.drop",  128'(m_stb), 128'(0));
        do_access("post", 1'b0, 32'h4000_0008, 4'b1111, 32'h0, 1, LA, -1, !RDBUF, 16'hFFFF, 32'hAAAA0002);

        // Reset in the middle of a write, then a stray downstream ack
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h5000_0000; sel = 4'hF; dat_w = 32'h12345678;
        tick();
        check("rstwr.stb", 128'(m_stb), 128'(1));
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
        rst = 1'b0;
        check("rstwr.cyc",  128'(m_cyc),   128'(0));
        check("rstwr.stb0", 128'(m_stb),   128'(0));
        check("rstwr.we",   128'(m_we),    128'(0));
        check("rstwr.adr",  128'(m_adr),   128'(0));
        check("rstwr.sel",  128'(m_sel),   128'(0));
        check("rstwr.mdat", m_dat_o,       128'(0));
        check("rstwr.ack",  128'(ack),     128'(0));
        check("rstwr.dat",  128'(dat_r),   128'(0));
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        check("stray.ack", 128'(ack),   128'(0));
        check("stray.stb", 128'(m_stb), 128'(0));
        tick();
        check("stray.ack2", 128'(ack), 128'(0));
        do_access("wr3", 1'b1, 32'h5000_000C, 4'b1100, 32'hCAFEF00D, 1, '0, -1, 1'b1, 16'hC000, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
